// File: rtl/l1a_match_tagger.sv
// rtl/l1a_match_tagger.sv - L1A event-number tagger feeding the L1A-number FIFO
//
// Counts every L1A into a 6-bit event number. Tracks one outstanding L1A at a
// time and accepts L1A_MATCH inside the timer window [WIN_OPEN, WIN_CLOSE].
//
// A match in the window produces a one-cycle PUSH carrying the tag and phase.
// An L1A that reaches the end of the window without a match is counted in
// MISS_CNT and dropped.
//
// Ports:
//   CLK, RST_B        clock, asynchronous active-low reset
//   L1A, L1A_PHASE_IN level-1 accept pulse and its phase bit
//   L1A_MATCH         match pulse for the outstanding L1A
//   L1ACNT_RST        synchronous event-number clear
//   FIFO_FULL         downstream FIFO full
//   PUSH, DL1AN,      FIFO write strobe with event number and phase;
//   L1A_PHASE         DL1AN and L1A_PHASE hold their values between pushes
//   L1A_NUM           running event counter
//   MISS_CNT          saturating unmatched-L1A count
//   STRAY_MATCH,      one-cycle error flags: match outside the window,
//   OVLP_ERR,         L1A while already waiting,
//   OVFL_ERR          matched push lost to FIFO_FULL
module l1a_match_tagger #(
  parameter int TMR       = 0,
  parameter int WIN_OPEN  = 2,
  parameter int WIN_CLOSE = 6
) (
  input  logic       CLK,
  input  logic       RST_B,
  input  logic       L1A,
  input  logic       L1A_PHASE_IN,
  input  logic       L1A_MATCH,
  input  logic       L1ACNT_RST,
  input  logic       FIFO_FULL,
  output logic       PUSH,
  output logic [5:0] DL1AN,
  output logic       L1A_PHASE,
  output logic [5:0] L1A_NUM,
  output logic [7:0] MISS_CNT,
  output logic       STRAY_MATCH,
  output logic       OVLP_ERR,
  output logic       OVFL_ERR
);

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  // Everything that is triplicated under TMR lives in this one record.
  typedef struct packed {
    state_t     state;
    logic [3:0] timer;
    logic [5:0] cnt;
  } core_t;

  localparam int NCOPY = (TMR != 0) ? 3 : 1;

  core_t core_q [NCOPY];
  core_t core_v;
  core_t core_d;

  logic       in_wait;
  logic       early;
  logic       match_ok;
  logic       timeout;
  logic       track;
  logic       stray_d;
  logic [5:0] tag_q;
  logic       phase_q;

  // Bitwise majority vote; every copy reloads from the voted value, so a
  // single upset copy is repaired on the next edge.
  generate
    if (TMR != 0) begin : g_vote
      assign core_v = core_t'((core_q[0] & core_q[1]) |
                              (core_q[0] & core_q[2]) |
                              (core_q[1] & core_q[2]));
    end else begin : g_single
      assign core_v = core_q[0];
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      for (int i = 0; i < NCOPY; i++) core_q[i] <= '0;
    end else begin
      for (int i = 0; i < NCOPY; i++) core_q[i] <= core_d;
    end
  end

  always_comb begin
    core_d   = core_v;
    in_wait  = (core_v.state == S_WAIT);
    early    = (core_v.timer < 4'(WIN_OPEN));
    match_ok = in_wait && L1A_MATCH && !early;
    timeout  = in_wait && !match_ok && (core_v.timer == 4'(WIN_CLOSE));
    track    = !in_wait && L1A;
    stray_d  = L1A_MATCH && (!in_wait || early);

    // Counter: a clear together with an L1A lands on 1, so the L1A is tagged 1.
    if (L1ACNT_RST)
      core_d.cnt = L1A ? 6'd1 : 6'd0;
    else if (L1A)
      core_d.cnt = core_v.cnt + 6'd1;

    case (core_v.state)
      S_IDLE: begin
        if (L1A) begin
          core_d.state = S_WAIT;
          core_d.timer = 4'd1;
        end
      end
      S_WAIT: begin
        if (match_ok || timeout) begin
          core_d.state = S_IDLE;
          core_d.timer = 4'd0;
        end else begin
          core_d.timer = core_v.timer + 4'd1;
        end
      end
      default: begin
        core_d.state = S_IDLE;
        core_d.timer = 4'd0;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RST_B) begin
    if (!RST_B) begin
      PUSH        <= 1'b0;
      DL1AN       <= '0;
      L1A_PHASE   <= 1'b0;
      MISS_CNT    <= '0;
      STRAY_MATCH <= 1'b0;
      OVLP_ERR    <= 1'b0;
      OVFL_ERR    <= 1'b0;
      tag_q       <= '0;
      phase_q     <= 1'b0;
    end else begin
      PUSH        <= match_ok && !FIFO_FULL;
      OVFL_ERR    <= match_ok && FIFO_FULL;
      STRAY_MATCH <= stray_d;
      OVLP_ERR    <= in_wait && L1A;
      if (match_ok && !FIFO_FULL) begin
        DL1AN     <= tag_q;
        L1A_PHASE <= phase_q;
      end
      if (timeout && (MISS_CNT != 8'hFF))
        MISS_CNT <= MISS_CNT + 8'd1;
      if (track) begin
        tag_q   <= core_d.cnt;
        phase_q <= L1A_PHASE_IN;
      end
    end
  end

  assign L1A_NUM = core_v.cnt;

endmodule

// File: tb/tb_l1a_match_tagger.sv
// tb/tb_l1a_match_tagger.sv - self-checking bench for l1a_match_tagger (TMR=0 and TMR=1)
module tb_l1a_match_tagger;

  localparam int WO = 2;
  localparam int WC = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_b, l1a, ph_in, match, cnt_rst, full;

  logic       push0, ph0, stray0, ovlp0, ovfl0;
  logic [5:0] dl0, num0;
  logic [7:0] miss0;
  logic       push1, ph1, stray1, ovlp1, ovfl1;
  logic [5:0] dl1, num1;
  logic [7:0] miss1;

  l1a_match_tagger #(.TMR(0), .WIN_OPEN(WO), .WIN_CLOSE(WC)) dut0 (
    .CLK(clk), .RST_B(rst_b), .L1A(l1a), .L1A_PHASE_IN(ph_in), .L1A_MATCH(match),
    .L1ACNT_RST(cnt_rst), .FIFO_FULL(full), .PUSH(push0), .DL1AN(dl0), .L1A_PHASE(ph0),
    .L1A_NUM(num0), .MISS_CNT(miss0), .STRAY_MATCH(stray0), .OVLP_ERR(ovlp0), .OVFL_ERR(ovfl0));

  l1a_match_tagger #(.TMR(1), .WIN_OPEN(WO), .WIN_CLOSE(WC)) dut1 (
    .CLK(clk), .RST_B(rst_b), .L1A(l1a), .L1A_PHASE_IN(ph_in), .L1A_MATCH(match),
    .L1ACNT_RST(cnt_rst), .FIFO_FULL(full), .PUSH(push1), .DL1AN(dl1), .L1A_PHASE(ph1),
    .L1A_NUM(num1), .MISS_CNT(miss1), .STRAY_MATCH(stray1), .OVLP_ERR(ovlp1), .OVFL_ERR(ovfl1));

  typedef struct packed {
    logic       push;
    logic [5:0] dl1an;
    logic       ph;
    logic [5:0] num;
    logic [7:0] miss;
    logic       stray;
    logic       ovlp;
    logic       ovfl;
  } out_t;

  out_t o0, o1, exp_o, pend;
  assign o0 = {push0, dl0, ph0, num0, miss0, stray0, ovlp0, ovfl0};
  assign o1 = {push1, dl1, ph1, num1, miss1, stray1, ovlp1, ovfl1};

  // Reference model: event-based, remembers the cycle of the tracked L1A.
  int m_cnt, m_t0, m_tag, m_miss, m_dl, m_cyc;
  bit m_trk, m_ph, m_dph;

  int n_vec = 0;
  int n_bad = 0;
  bit chk_en = 0;

  task automatic cmp(input string nm, input int act, input int ex);
    n_vec++;
    if (act != ex) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d at %0t", nm, act, ex, $time);
    end
  endtask

  task automatic check_out(input string t, input out_t a, input out_t e);
    cmp({t, ".push"},  int'(a.push),  int'(e.push));
    cmp({t, ".dl1an"}, int'(a.dl1an), int'(e.dl1an));
    cmp({t, ".phase"}, int'(a.ph),    int'(e.ph));
    cmp({t, ".num"},   int'(a.num),   int'(e.num));
    cmp({t, ".miss"},  int'(a.miss),  int'(e.miss));
    cmp({t, ".stray"}, int'(a.stray), int'(e.stray));
    cmp({t, ".ovlp"},  int'(a.ovlp),  int'(e.ovlp));
    cmp({t, ".ovfl"},  int'(a.ovfl),  int'(e.ovfl));
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      check_out("tmr0", o0, exp_o);
      check_out("tmr1", o1, exp_o);
    end
  end

  task automatic model_reset();
    m_cnt = 0; m_trk = 0; m_t0 = 0; m_tag = 0; m_ph = 0;
    m_miss = 0; m_dl = 0; m_dph = 0; m_cyc = 0;
    pend = '0;
    exp_o = '0;
  endtask

  // Outputs expected after the coming edge, from this cycle's inputs.
  task automatic model_step();
    int k;
    bit mok, endn;
    k = m_cyc - m_t0;
    pend = '0;
    mok = m_trk && match && (k >= WO);
    pend.stray = match && !mok;
    pend.ovlp = m_trk && l1a;
    if (mok) begin
      if (full) pend.ovfl = 1'b1;
      else begin
        pend.push = 1'b1;
        m_dl = m_tag;
        m_dph = m_ph;
      end
    end else if (m_trk && k == WC) begin
      m_miss = (m_miss < 255) ? m_miss + 1 : 255;
    end
    endn = m_trk && (mok || k == WC);
    if (cnt_rst) m_cnt = l1a ? 1 : 0;
    else if (l1a) m_cnt = (m_cnt + 1) % 64;
    if (!m_trk && l1a) begin
      m_trk = 1; m_t0 = m_cyc; m_tag = m_cnt; m_ph = ph_in;
    end else if (endn) begin
      m_trk = 0;
    end
    pend.dl1an = 6'(m_dl);
    pend.ph = m_dph;
    pend.num = 6'(m_cnt);
    pend.miss = 8'(m_miss);
    m_cyc++;
  endtask

  // Called at posedge+1; returns at the next posedge+1.
  task automatic tick(input bit l, input bit p, input bit m, input bit c, input bit f);
    l1a = l; ph_in = p; match = m; cnt_rst = c; full = f;
    if (rst_b) model_step();
    else pend = '0;
    @(posedge clk);
    #1;
    exp_o = pend;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick(0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    rst_b = 1'b0;
    model_reset();
    idle(2);
    rst_b = 1'b1;
    idle(1);
  endtask

  initial begin
    rst_b = 1'b0; l1a = 0; ph_in = 0; match = 0; cnt_rst = 0; full = 0;
    model_reset();
    @(posedge clk);
    #1;
    chk_en = 1;
    cmp("reset.num", int'(num0), 0);
    cmp("reset.push", int'(push0), 0);
    do_reset();

    // L1A, match three cycles later, single push carrying tag 1
    tick(1, 1, 0, 0, 0);
    idle(2);
    tick(0, 0, 1, 0, 0);
    cmp("t1.push", int'(push0), 1);
    cmp("t1.dl1an", int'(dl0), 1);
    cmp("t1.phase", int'(ph0), 1);
    cmp("t1.num", int'(num0), 1);
    idle(1);
    cmp("t1.push_once", int'(push0), 0);

    // Early match is stray; window runs out into a miss; late match is stray
    do_reset();
    tick(1, 0, 0, 0, 0);
    tick(0, 0, 1, 0, 0);
    cmp("t3.stray", int'(stray0), 1);
    idle(5);
    cmp("t3.miss", int'(miss0), 1);
    tick(0, 0, 1, 0, 0);
    cmp("t3.late_stray", int'(stray0), 1);
    cmp("t3.no_push", int'(push0), 0);

    // Overlapping L1A is flagged and not tracked
    do_reset();
    tick(1, 0, 0, 0, 0);
    idle(1);
    tick(1, 0, 0, 0, 0);
    cmp("t4.ovlp", int'(ovlp0), 1);
    idle(1);
    tick(0, 0, 1, 0, 0);
    cmp("t4.push", int'(push0), 1);
    cmp("t4.dl1an", int'(dl0), 1);
    cmp("t4.num", int'(num0), 2);

    // Event number wrap and counter clear with simultaneous L1A
    do_reset();
    for (int i = 0; i < 64; i++) begin
      tick(1, 1'($urandom), 0, 0, 0);
      idle(1);
      tick(0, 0, 1, 0, 0);
      cmp("t5.dl1an", int'(dl0), (i + 1) % 64);
    end
    tick(1, 0, 0, 1, 0);
    idle(1);
    tick(0, 0, 1, 0, 0);
    cmp("t5.clr_dl1an", int'(dl0), 1);
    cmp("t5.clr_num", int'(num0), 1);

    // FIFO full drops the push; reset in the middle of WAIT clears everything
    do_reset();
    tick(1, 0, 0, 0, 1);
    tick(0, 0, 0, 0, 1);
    tick(0, 0, 1, 0, 1);
    cmp("t6.ovfl", int'(ovfl0), 1);
    cmp("t6.push", int'(push0), 0);
    cmp("t6.miss", int'(miss0), 0);
    idle(1);
    cmp("t6.ovfl_once", int'(ovfl0), 0);
    tick(1, 1, 0, 0, 0);
    idle(1);
    rst_b = 1'b0;
    model_reset();
    #1;
    cmp("t6.rst_num", int'(num0), 0);
    cmp("t6.rst_dl1an", int'(dl0), 0);
    idle(2);
    rst_b = 1'b1;
    idle(8);
    cmp("t6.no_push", int'(push0), 0);

    // Random traffic against the model
    do_reset();
    for (int i = 0; i < 4000; i++)
      tick($urandom_range(0, 5) == 0, 1'($urandom), $urandom_range(0, 3) == 0,
           $urandom_range(0, 63) == 0, $urandom_range(0, 4) == 0);

    // Miss counter saturation
    do_reset();
    tick(1, 0, 0, 0, 0);
    idle(6);
    cmp("t2.miss1", int'(miss0), 1);
    for (int i = 0; i < 299; i++) begin
      tick(1, 0, 0, 0, 0);
      idle(6);
    end
    cmp("t2.miss_sat", int'(miss0), 255);
    idle(2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
